serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Sequencing controller for the team's bit-serial adder cell (full adder plus carry flip-flop with enable and clear). Accepts two WIDTH-bit operands on a start/done handshake, captures them, and clears the carry. It then feeds the cell one bit pair per clock, LSB first, and collects the serial sum into a parallel result with carry-out. It sits between parallel register-level logic and the single-bit serial datapath.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2–32.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- a_in  in  WIDTH  operand A; captured on the accepted start edge.
- b_in  in  WIDTH  operand B; captured on the accepted start edge.
- busy  out  1  high in CLR and SHIFT; low in IDLE and DONE.
- done  out  1  one-cycle pulse in DONE.
- sum  out  WIDTH  result; valid from the done pulse until the next accepted start.
- cout  out  1  final carry; same validity as sum.

## Operation
- States:
  - IDLE: waiting for start.
  - CLR: clears the adder carry.
  - SHIFT: feeds bit pairs to the adder.
  - DONE: reports the result.
- IDLE→CLR when start=1:
  - a_in/b_in go into shift registers a_sr/b_sr.
  - bit counter cnt ← 0.
- CLR→SHIFT unconditionally:
  - adder clear=1, en=0; carry ← 0.
  - sum register ← 0.
- SHIFT:
  - cell inputs: A = a_sr[0], B = b_sr[0]; en=1, clear=0.
  - each cycle: a_sr/b_sr shift right, zero-fill.
  - sum shifts right with the cell's S into the MSB.
  - cnt increments.
  - when cnt = WIDTH−1 → DONE; that cycle's edge takes the final bit.
- DONE:
  - done=1; cout = carry flip-flop value (en=0, so it holds); sum holds.
  - → IDLE unconditionally.
- start is ignored in CLR, SHIFT and DONE. No queueing; the requester must re-assert in IDLE.
- Addition is unsigned modulo 2^WIDTH; overflow is reported only through cout.
- sum and cout hold their last values while idle. They clear to 0 in CLR of the next operation.
- cnt width is $clog2(WIDTH).

## Timing
- Reset (rst_n=0, any state, asynchronous):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - a_sr=b_sr=0; cnt=0; adder carry=0.
  - An operation in flight is abandoned with no done pulse.
- Reset release: first rising edge with rst_n=1 may accept start.
- Latency: start sampled high at edge t → CLR during cycle t..t+1 → SHIFT for WIDTH cycles → done high for exactly one cycle starting at edge t+WIDTH+1.
- Total occupancy is WIDTH+2 cycles.
- Back-to-back: start held high through DONE is accepted on the first edge in IDLE. The minimum start-to-start interval is WIDTH+3 cycles.
- busy rises the edge after start is accepted and falls on the edge that enters DONE.
- All outputs are registered, with no combinational path from start/a_in/b_in. The adder S feeds the sum register only.
- Operand changes after capture do not affect the result.

## Structure
- Shared package serial_pkg:
  - state encoding localparams: ST_IDLE=2'd0, ST_CLR=2'd1, ST_SHIFT=2'd2, ST_DONE=2'd3.
  - default WIDTH.
- One sub-module, serial_add_bit:
  - ports: clk, rst_n, clear, en, a, b; outputs s (combinational a^b^c) and c (carry flip-flop).
  - carry updates only when en=1; clear has priority over en.
- Controller: one FSM always block, plus registered datapath for a_sr, b_sr, sum and cnt.

## Test plan
- WIDTH=8, a_in=8'h5A, b_in=8'h33, start pulse → done one cycle at start+9 edges; sum=8'h8D, cout=0; busy high exactly 9 cycles.
- a_in=8'hFF, b_in=8'h01 → sum=8'h00, cout=1.
- Then a_in=8'h00, b_in=8'h00 → sum=8'h00, cout=0, proving the carry was cleared.
- start re-pulsed during SHIFT with a_in=8'h01, b_in=8'h01 → ignored; the first result completes unchanged; no second done.
- rst_n low mid-SHIFT (3 bits in), then release → all outputs 0, no done. A fresh 8'h10+8'h20 yields 8'h30.
- start held high continuously with 8'h80+8'h80 → done pulses every 11 cycles; each result sum=8'h00, cout=1.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding
// and the default operand width.
package serial_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLR   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/serial_add_bit.sv
// Bit-serial adder cell: combinational full-adder sum plus a carry flip-flop
// with enable and a clear that takes priority over the enable.
module serial_add_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    logic r_carry;

    // NOTE: sequential state is always written with <= so every flop samples
    // the pre-edge values, regardless of the order of statements or blocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry <= 1'b0;
        end else if (clear) begin
            r_carry <= 1'b0;
        end else if (en) begin
            r_carry <= (a & b) | (r_carry & (a ^ b));
        end
    end

    assign s = a ^ b ^ r_carry;
    assign c = r_carry;

endmodule

// File: rtl/serial_add_ctrl.sv
// Sequencing controller for serial_add_bit: captures two operands, clears the
// carry, streams bit pairs LSB first and assembles the parallel sum and carry-out.
module serial_add_ctrl
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_sum;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_clear;
    logic               w_en;
    logic               w_s;
    logic               w_carry;
    logic               w_last_bit;

    assign w_last_bit = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal driven here gets a default before the case so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_en         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_CLR;
                end
            end
            ST_CLR: begin
                w_clear      = 1'b1;
                w_next_state = ST_SHIFT;
            end
            ST_SHIFT: begin
                w_en = 1'b1;
                if (w_last_bit) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr <= '0;
            r_b_sr <= '0;
            r_sum  <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a_sr <= a_in;
                        r_b_sr <= b_in;
                        r_cnt  <= '0;
                    end
                end
                ST_CLR: begin
                    r_sum <= '0;
                end
                ST_SHIFT: begin
                    r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_sum  <= {w_s, r_sum[WIDTH-1:1]};
                    r_cnt  <= r_cnt + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    serial_add_bit u_add_bit (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_clear),
        .en    (w_en),
        .a     (r_a_sr[0]),
        .b     (r_b_sr[0]),
        .s     (w_s),
        .c     (w_carry)
    );

    // The carry flop is idle outside SHIFT, so it doubles as the held carry-out.
    assign busy = (r_state == ST_CLR) || (r_state == ST_SHIFT);
    assign done = (r_state == ST_DONE);
    assign sum  = r_sum;
    assign cout = w_carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed vector table,
// multi-cycle corner sequences and randomized operations against a model.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_checks = 0;
    int n_errors = 0;
    int busy_cycles;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[7];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Present operands for one edge, then scramble them to show capture.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(negedge clk);
        start = 1'b0;
        a_in  = W'($urandom);
        b_in  = W'($urandom);
    endtask

    // Counts negedges until done; returns the count, and busy_cycles seen.
    task automatic wait_done(output int lat);
        lat = 0;
        busy_cycles = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            lat++;
        end
        if (!done) check("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic run_and_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] exp_sum, input logic exp_cout);
        int lat;
        launch(a, b);
        wait_done(lat);
        check({name, "_latency"}, lat, W + 1);
        check({name, "_sum"}, sum, exp_sum);
        check({name, "_cout"}, cout, exp_cout);
        check({name, "_busy_in_done"}, busy, 0);
        @(negedge clk);
        check({name, "_done_one_cycle"}, done, 0);
    endtask

    function automatic logic [W:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned total;
        total = int'(a) + int'(b);
        return (W + 1)'(total);
    endfunction

    initial begin
        int lat;
        int dones;
        int pulse_at[$];
        logic [W:0] ref_val;

        vecs[0] = '{8'h5A, 8'h33, 8'h8D, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
        vecs[4] = '{8'h80, 8'h7F, 8'hFF, 1'b0};
        vecs[5] = '{8'hAA, 8'h55, 8'hFF, 1'b0};
        vecs[6] = '{8'h01, 8'hFF, 8'h00, 1'b1};

        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_sum", sum, 0);
        check("reset_cout", cout, 0);
        rst_n = 1'b1;

        // First operation also checks busy duration.
        launch(vecs[0].a, vecs[0].b);
        wait_done(lat);
        check("first_latency", lat, 9);
        check("first_busy_cycles", busy_cycles, 9);
        check("first_sum", sum, 8'h8D);
        check("first_cout", cout, 0);

        for (int i = 1; i < 7; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_sum, vecs[i].exp_cout);
        end

        // Results hold while idle.
        run_and_check("hold_setup", 8'hC3, 8'h4F, 8'h12, 1'b1);
        repeat (5) @(negedge clk);
        check("hold_sum", sum, 8'h12);
        check("hold_cout", cout, 1);

        // start re-pulsed during SHIFT is ignored.
        launch(8'h5A, 8'h33);
        repeat (3) @(negedge clk);
        start = 1'b1;
        a_in  = 8'h01;
        b_in  = 8'h01;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check("ignore_latency", lat + 4, 9);
        check("ignore_sum", sum, 8'h8D);
        check("ignore_cout", cout, 0);
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("ignore_no_second_done", dones, 0);

        // Reset mid-SHIFT after 3 bits.
        launch(8'hEE, 8'hEE);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_sum", sum, 0);
        check("midrst_cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        check("midrst_no_activity", dones, 0);
        run_and_check("after_rst", 8'h10, 8'h20, 8'h30, 1'b0);

        // start held high: back-to-back operations.
        @(negedge clk);
        start = 1'b1;
        a_in  = 8'h80;
        b_in  = 8'h80;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) begin
                pulse_at.push_back(c);
                check("b2b_sum", sum, 8'h00);
                check("b2b_cout", cout, 1);
            end
        end
        start = 1'b0;
        check("b2b_pulse_count", pulse_at.size(), 3);
        for (int i = 1; i < pulse_at.size(); i++) begin
            check("b2b_interval", pulse_at[i] - pulse_at[i-1], 11);
        end
        repeat (12) @(negedge clk);

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 25; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = W'($urandom);
            ref_val = model_add(ra, rb);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_and_check($sformatf("rand%0d", i), ra, rb, ref_val[W-1:0], ref_val[W]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
